// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding data-memory access at a time. Computes the
// effective address, lane-aligns stores, extracts and extends load data.
//
// state | meaning
// IDLE  | ready for an issue; misaligned accepts stay here and pulse misalign_o
// REQ   | request on the bus, held stable until dmem_ack_i
// RESP  | acked; a non-killed load broadcasts its result on the next edge
module mem_access_unit #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int RRF_SEL  = 6
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                issue_valid_i,
    input  logic [DATA_LEN-1:0] issue_op_1_i,
    input  logic [DATA_LEN-1:0] issue_op_2_i,
    input  logic [DATA_LEN-1:0] issue_imm_i,
    input  logic [RRF_SEL-1:0]  issue_rrf_tag_i,
    input  logic                issue_dst_val_i,
    input  logic                issue_store_i,
    input  logic [1:0]          issue_size_i,
    input  logic                issue_unsigned_i,
    input  logic                kill_i,
    output logic                ready_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_LEN-1:0] dmem_addr_o,
    output logic [DATA_LEN-1:0] dmem_wdata_o,
    output logic [3:0]          dmem_wstrb_o,
    input  logic                dmem_ack_i,
    input  logic [DATA_LEN-1:0] dmem_rdata_i,
    output logic                result_valid_o,
    output logic [DATA_LEN-1:0] result_o,
    output logic [RRF_SEL-1:0]  result_dst_o,
    output logic                result_dst_val_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                killed;
    logic                store_q;
    logic                unsigned_q;
    logic [1:0]          size_q;
    logic [1:0]          addr_lo;
    logic [RRF_SEL-1:0]  dst_q;
    logic                dst_val_q;
    logic [3:0]          strb_q;
    logic [DATA_LEN-1:0] load_data;

    logic [ADDR_LEN-1:0] eff_addr;
    logic                accept;
    logic                misaligned;
    logic [DATA_LEN-1:0] wdata_rep;
    logic [3:0]          strb_calc;
    logic [DATA_LEN-1:0] rd_shift;
    logic [DATA_LEN-1:0] rd_ext;

    always_comb begin
        eff_addr   = ADDR_LEN'(issue_op_1_i + issue_imm_i);
        accept     = issue_valid_i && (state == IDLE) && !kill_i;
        misaligned = ((issue_size_i == 2'd1) && eff_addr[0]) ||
                     (issue_size_i[1] && (eff_addr[1:0] != 2'b00));
    end

    // Store lane replication and strobes; loads never write.
    always_comb begin
        wdata_rep = issue_op_2_i;
        strb_calc = 4'b0000;
        case (issue_size_i)
            2'd0: begin
                wdata_rep = {(DATA_LEN/8){issue_op_2_i[7:0]}};
                strb_calc = 4'b0001 << eff_addr[1:0];
            end
            2'd1: begin
                wdata_rep = {(DATA_LEN/16){issue_op_2_i[15:0]}};
                strb_calc = 4'b0011 << eff_addr[1:0];
            end
            default: strb_calc = 4'b1111;
        endcase
        if (!issue_store_i)
            strb_calc = 4'b0000;
    end

    always_comb begin
        rd_shift = dmem_rdata_i >> {addr_lo, 3'b000};
        case (size_q)
            2'd0:    rd_ext = {{(DATA_LEN-8){~unsigned_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = {{(DATA_LEN-16){~unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ready_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_wstrb_o = 4'b0000;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (accept && !misaligned)
                    state_nxt = REQ;
            end
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = store_q;
                dmem_wstrb_o = strb_q;
                if (dmem_ack_i)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            killed           <= 1'b0;
            store_q          <= 1'b0;
            unsigned_q       <= 1'b0;
            size_q           <= 2'd0;
            addr_lo          <= 2'd0;
            dst_q            <= '0;
            dst_val_q        <= 1'b0;
            strb_q           <= 4'b0000;
            load_data        <= '0;
            dmem_addr_o      <= '0;
            dmem_wdata_o     <= '0;
            result_valid_o   <= 1'b0;
            result_o         <= '0;
            result_dst_o     <= '0;
            result_dst_val_o <= 1'b0;
            misalign_o       <= 1'b0;
        end else begin
            misalign_o     <= accept && misaligned;
            result_valid_o <= 1'b0;
            // Misaligned accepts leave the bus-facing registers untouched.
            if (accept && !misaligned) begin
                killed       <= 1'b0;
                store_q      <= issue_store_i;
                unsigned_q   <= issue_unsigned_i;
                size_q       <= issue_size_i;
                addr_lo      <= eff_addr[1:0];
                dst_q        <= issue_rrf_tag_i;
                dst_val_q    <= issue_dst_val_i;
                strb_q       <= strb_calc;
                dmem_addr_o  <= {eff_addr[ADDR_LEN-1:2], 2'b00};
                dmem_wdata_o <= wdata_rep;
            end
            if (state == REQ) begin
                if (kill_i)
                    killed <= 1'b1;
                if (dmem_ack_i)
                    load_data <= rd_ext;
            end
            if ((state == RESP) && !store_q && !killed && !kill_i) begin
                result_valid_o   <= 1'b1;
                result_o         <= load_data;
                result_dst_o     <= dst_q;
                result_dst_val_o <= dst_val_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a vector table of single accesses plus hand-built
// sequences for kill, reset and back-to-back issue; load results go via a scoreboard.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_valid_i;
    logic [31:0] issue_op_1_i;
    logic [31:0] issue_op_2_i;
    logic [31:0] issue_imm_i;
    logic [5:0]  issue_rrf_tag_i;
    logic        issue_dst_val_i;
    logic        issue_store_i;
    logic [1:0]  issue_size_i;
    logic        issue_unsigned_i;
    logic        kill_i;
    logic        ready_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [5:0]  result_dst_o;
    logic        result_dst_val_o;
    logic        misalign_o;

    mem_access_unit #(.ADDR_LEN(32), .DATA_LEN(32), .RRF_SEL(6)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .issue_valid_i(issue_valid_i), .issue_op_1_i(issue_op_1_i),
        .issue_op_2_i(issue_op_2_i), .issue_imm_i(issue_imm_i),
        .issue_rrf_tag_i(issue_rrf_tag_i), .issue_dst_val_i(issue_dst_val_i),
        .issue_store_i(issue_store_i), .issue_size_i(issue_size_i),
        .issue_unsigned_i(issue_unsigned_i), .kill_i(kill_i),
        .ready_o(ready_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .result_valid_o(result_valid_o),
        .result_o(result_o), .result_dst_o(result_dst_o),
        .result_dst_val_o(result_dst_val_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] op1;
        logic [31:0] imm;
        logic [31:0] op2;
        logic [31:0] rdata;
        int          wt;
        logic        mis;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        logic        dv;
    } sb_t;

    vec_t vecs[14];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   req_cnt = 0;
    int   rv_cnt = 0;
    logic prev_req = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every cycle advance goes through here so results are never missed.
    task automatic tick();
        sb_t e;
        @(negedge clk_i);
        if (result_valid_o === 1'b1) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_result_valid", {31'b0, result_valid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("result_dst", {26'b0, result_dst_o}, {26'b0, e.tag});
                check("result_dst_val", {31'b0, result_dst_val_o}, {31'b0, e.dv});
            end
        end
        if (dmem_req_o && !prev_req)
            req_cnt++;
        prev_req = dmem_req_o;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", {31'b0, ready_o}, 32'd1);
    endtask

    task automatic drive_issue(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] op1, input logic [31:0] imm,
                               input logic [31:0] op2, input logic [5:0] tag, input logic dv);
        issue_valid_i    = 1'b1;
        issue_store_i    = st;
        issue_size_i     = sz;
        issue_unsigned_i = uns;
        issue_op_1_i     = op1;
        issue_imm_i      = imm;
        issue_op_2_i     = op2;
        issue_rrf_tag_i  = tag;
        issue_dst_val_i  = dv;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        sb_t  e;
        v = vecs[i];
        wait_ready();
        drive_issue(v.st, v.sz, v.uns, v.op1, v.imm, v.op2, 6'(i + 1), (i % 3) != 0);
        if (!v.st && !v.mis) begin
            e.res = v.e_res;
            e.tag = 6'(i + 1);
            e.dv  = (i % 3) != 0;
            sb.push_back(e);
        end
        tick();
        issue_valid_i = 1'b0;
        if (v.mis) begin
            check("misalign_pulse", {31'b0, misalign_o}, 32'd1);
            check("misalign_no_req", {31'b0, dmem_req_o}, 32'd0);
            check("misalign_ready", {31'b0, ready_o}, 32'd1);
            tick();
            check("misalign_one_cycle", {31'b0, misalign_o}, 32'd0);
            return;
        end
        check("req", {31'b0, dmem_req_o}, 32'd1);
        check("addr", dmem_addr_o, v.e_addr);
        check("we", {31'b0, dmem_we_o}, {31'b0, v.st});
        check("wstrb", {28'b0, dmem_wstrb_o}, {28'b0, v.e_strb});
        if (v.st)
            check("wdata", dmem_wdata_o, v.e_wdata);
        for (int w = 0; w < v.wt; w++) begin
            tick();
            check("req_held", {31'b0, dmem_req_o}, 32'd1);
            check("addr_held", dmem_addr_o, v.e_addr);
        end
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = v.rdata;
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = $urandom;
        check("req_drop_after_ack", {31'b0, dmem_req_o}, 32'd0);
        check("resp_not_ready", {31'b0, ready_o}, 32'd0);
        tick();
        check("ready_at_ack_plus_2", {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        int rv0, rq0;
        sb_t e;

        //          st   sz    uns   op1           imm           op2           rdata         wt mis  e_addr        e_wdata       e_strb   e_res
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'd3,        32'h0,        32'h80AA_BBCC, 0, 1'b0, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1000, 32'd1,        32'h0,        32'h80AA_BBCC, 1, 1'b0, 32'h0000_1000, 32'h0,        4'b0000, 32'h0000_00BB};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_1000, 32'd2,        32'h0,        32'h80AA_BBCC, 0, 1'b0, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFF_80AA};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'd0,        32'h0,        32'h80AA_BBCC, 2, 1'b0, 32'h0000_1000, 32'h0,        4'b0000, 32'h0000_BBCC};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'd4,        32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_2004, 32'h0,        4'b0000, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'd0,        32'h0,        32'h1234_5678, 1, 1'b0, 32'h0000_3000, 32'h0,        4'b0000, 32'h1234_5678};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h0000_4000, 32'd2,        32'h1234_ABCD, 32'h0,        0, 1'b0, 32'h0000_4000, 32'hCDCD_CDCD, 4'b0100, 32'h0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'd0,        32'h1234_ABCD, 32'h0,        3, 1'b0, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'd8,        32'hCAFE_F00D, 32'h0,        1, 1'b0, 32'h0000_5008, 32'hCAFE_F00D, 4'b1111, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd1,        32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_1000, 32'd3,        32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1'b1, 2'd3, 1'b0, 32'h0000_1000, 32'd2,        32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'd5,        32'h0,        32'h0000_0001, 0, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 32'h0000_0001};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,       32'h7F00_0000, 0, 1'b0, 32'h0000_0FFC, 32'h0,        4'b0000, 32'h0000_007F};

        reset_i = 1'b0;
        issue_valid_i = 1'b0; issue_op_1_i = '0; issue_op_2_i = '0; issue_imm_i = '0;
        issue_rrf_tag_i = '0; issue_dst_val_i = 1'b0; issue_store_i = 1'b0;
        issue_size_i = 2'd0; issue_unsigned_i = 1'b0; kill_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        repeat (3) tick();
        check("rst_req", {31'b0, dmem_req_o}, 32'd0);
        check("rst_we", {31'b0, dmem_we_o}, 32'd0);
        check("rst_wstrb", {28'b0, dmem_wstrb_o}, 32'd0);
        check("rst_result_valid", {31'b0, result_valid_o}, 32'd0);
        check("rst_dst_val", {31'b0, result_dst_val_o}, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        check("rst_wdata", dmem_wdata_o, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_dst", {26'b0, result_dst_o}, 32'd0);
        reset_i = 1'b1;
        tick();
        check("ready_after_reset", {31'b0, ready_o}, 32'd1);

        for (int i = 0; i < 14; i++)
            run_vec(i);

        // Load-byte timing: result exactly at T+3, one cycle wide.
        e.res = 32'hFFFF_FF80; e.tag = 6'd5; e.dv = 1'b1;
        sb.push_back(e);
        drive_issue(1'b0, 2'd0, 1'b0, 32'h1000, 32'd3, 32'h0, 6'd5, 1'b1);
        tick();
        issue_valid_i = 1'b0;
        check("t1_not_ready", {31'b0, ready_o}, 32'd0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80AA_BBCC;
        tick();
        dmem_ack_i = 1'b0;
        check("t2_no_result", {31'b0, result_valid_o}, 32'd0);
        tick();
        check("t3_result_valid", {31'b0, result_valid_o}, 32'd1);
        check("t3_ready", {31'b0, ready_o}, 32'd1);
        tick();
        check("t4_result_dropped", {31'b0, result_valid_o}, 32'd0);

        // Kill while idle blocks accept.
        drive_issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 32'h0, 6'd7, 1'b1);
        kill_i = 1'b1;
        tick();
        issue_valid_i = 1'b0; kill_i = 1'b0;
        check("kill_idle_no_req", {31'b0, dmem_req_o}, 32'd0);
        check("kill_idle_ready", {31'b0, ready_o}, 32'd1);

        // Kill in the first REQ cycle; request completes, no result.
        rv0 = rv_cnt;
        drive_issue(1'b0, 2'd2, 1'b0, 32'h1100, 32'd0, 32'h0, 6'd8, 1'b1);
        tick();
        issue_valid_i = 1'b0;
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill_req_held1", {31'b0, dmem_req_o}, 32'd1);
        tick();
        check("kill_req_held2", {31'b0, dmem_req_o}, 32'd1);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        tick();
        dmem_ack_i = 1'b0;
        check("kill_req_done", {31'b0, dmem_req_o}, 32'd0);
        tick();
        check("kill_req_ready", {31'b0, ready_o}, 32'd1);
        tick();
        check("kill_req_no_result", rv_cnt, rv0);

        // Kill in RESP suppresses the broadcast.
        rv0 = rv_cnt;
        drive_issue(1'b0, 2'd2, 1'b0, 32'h1200, 32'd0, 32'h0, 6'd9, 1'b1);
        tick();
        issue_valid_i = 1'b0;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h3333_4444;
        tick();
        dmem_ack_i = 1'b0;
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill_resp_ready", {31'b0, ready_o}, 32'd1);
        tick();
        check("kill_resp_no_result", rv_cnt, rv0);

        // Reset while the request is up; a stale ack afterwards does nothing.
        rv0 = rv_cnt;
        drive_issue(1'b0, 2'd2, 1'b0, 32'h1300, 32'd0, 32'h0, 6'd10, 1'b1);
        tick();
        issue_valid_i = 1'b0;
        check("rst_mid_req_up", {31'b0, dmem_req_o}, 32'd1);
        reset_i = 1'b0;
        tick();
        check("rst_mid_req_dropped", {31'b0, dmem_req_o}, 32'd0);
        check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        check("rst_mid_addr_cleared", dmem_addr_o, 32'd0);
        check("rst_mid_result_cleared", result_o, 32'd0);
        reset_i = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h9999_9999;
        tick();
        dmem_ack_i = 1'b0;
        check("stale_ack_no_req", {31'b0, dmem_req_o}, 32'd0);
        check("stale_ack_ready", {31'b0, ready_o}, 32'd1);
        repeat (2) tick();
        check("stale_ack_no_result", rv_cnt, rv0);

        // Back-to-back: second issue held through REQ/RESP is taken only once idle.
        rq0 = req_cnt;
        e.res = 32'h1111_1111; e.tag = 6'd20; e.dv = 1'b1; sb.push_back(e);
        e.res = 32'h2222_2222; e.tag = 6'd21; e.dv = 1'b0; sb.push_back(e);
        drive_issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'd0, 32'h0, 6'd20, 1'b1);
        tick();
        check("b2b_addr_a", dmem_addr_o, 32'h6000);
        drive_issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'd4, 32'h0, 6'd21, 1'b0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
        tick();
        dmem_ack_i = 1'b0;
        tick();
        check("b2b_ready_again", {31'b0, ready_o}, 32'd1);
        tick();
        issue_valid_i = 1'b0;
        check("b2b_req_b", {31'b0, dmem_req_o}, 32'd1);
        check("b2b_addr_b", dmem_addr_o, 32'h7004);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h2222_2222;
        tick();
        dmem_ack_i = 1'b0;
        repeat (3) tick();
        check("b2b_two_requests", req_cnt - rq0, 32'd2);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width.
- RRF_SEL, 6, rename-register tag width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, the single clock.
- reset_i, in, 1, synchronous, active-low reset.
- issue_valid_i, in, 1, load/store issued from the select/wakeup stage.
- issue_op_1_i, in, DATA_LEN, base operand.
- issue_op_2_i, in, DATA_LEN, store data.
- issue_imm_i, in, DATA_LEN, offset.
- issue_rrf_tag_i, in, RRF_SEL, destination tag.
- issue_dst_val_i, in, 1, destination register valid.
- issue_store_i, in, 1, 1 = store, 0 = load.
- issue_size_i, in, 2, 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- issue_unsigned_i, in, 1, zero-extend load.
- kill_i, in, 1, pipeline flush.
- ready_o, out, 1, can accept issue this cycle.
- dmem_req_o, out, 1, memory request.
- dmem_we_o, out, 1, write request.
- dmem_addr_o, out, ADDR_LEN, word-aligned address.
- dmem_wdata_o, out, DATA_LEN, lane-aligned store data.
- dmem_wstrb_o, out, 4, byte strobes.
- dmem_ack_i, in, 1, request done; rdata valid same cycle.
- dmem_rdata_i, in, DATA_LEN, read word.
- result_valid_o, out, 1, load result broadcast.
- result_o, out, DATA_LEN, extended load data.
- result_dst_o, out, RRF_SEL, result tag.
- result_dst_val_o, out, 1, result writes a register.
- misalign_o, out, 1, misaligned access pulse.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, RESP.
REQ-004 ready_o SHALL be 1 only in IDLE; issue_valid_i outside IDLE SHALL be ignored.
REQ-005 Accept occurs when issue_valid_i & ready_o & ~kill_i; accept at cycle T SHALL latch all issue fields and compute eff_addr = op_1 + imm, truncated mod 2^ADDR_LEN.
REQ-006 Misaligned access (half with eff_addr[0]=1, or word/reserved with eff_addr[1:0]!=0) SHALL issue no request, pulse misalign_o for one cycle at T+1, produce no result, and stay in IDLE.
REQ-007 Aligned accept SHALL enter REQ at T+1, driving the following held stable until ack:
- dmem_req_o = 1
- dmem_addr_o = {eff_addr[ADDR_LEN-1:2], 2'b00}
- dmem_we_o = store
REQ-008 Store wdata SHALL be store data replicated per lane:
- byte: 4 copies of [7:0]
- half: 2 copies of [15:0]
- word: unchanged
REQ-009 Store wstrb SHALL be:
- byte: 1 << addr[1:0]
- half: 4'b0011 << addr[1:0]
- word: 4'b1111
REQ-010 Load wstrb SHALL be 0.
REQ-011 dmem_ack_i sampled high in REQ (including the first REQ cycle) SHALL move to RESP and capture the extracted load value: rdata >> (8*addr[1:0]), then sign- or zero-extended from the size.
REQ-012 In RESP, result_valid_o SHALL be 1 for exactly one cycle, only for non-killed loads; result_dst_o and result_dst_val_o SHALL be the latched values. RESP SHALL then go to IDLE, so ready_o rises at A+2 for ack at cycle A.
REQ-013 Stores SHALL pass through RESP with result_valid_o = 0.
REQ-014 Load latency from accept to result SHALL be 3 cycles with zero-wait ack.
REQ-015 kill_i in REQ SHALL set a killed flag; the request SHALL still complete (no abandonment of an outstanding bus transaction), and no result SHALL be broadcast.
REQ-016 kill_i in RESP SHALL suppress result_valid_o that cycle.
REQ-017 kill_i in IDLE SHALL block accept.
REQ-018 dmem_ack_i outside REQ SHALL be ignored.
REQ-019 dmem_req_o SHALL deassert the cycle after ack.
REQ-020 When not valid, result_o, result_dst_o and dmem_wdata_o SHALL hold their last values; only the valid/req/misalign strobes are qualified.

Reset
REQ-021 reset_i = 0 at a clock edge SHALL force IDLE and clear the killed flag, with the following outputs at 0:
- dmem_req_o, dmem_we_o, dmem_wstrb_o
- result_valid_o, result_dst_val_o
- misalign_o
- dmem_addr_o, dmem_wdata_o, result_o, result_dst_o
REQ-022 Reset mid-transaction SHALL drop the request immediately; a later ack SHALL be ignored.
REQ-023 ready_o SHALL be 1 the first cycle after reset release.

Verification
REQ-024 Load byte signed: op_1 = 0x1000, imm = 3, size 0, tag 5, ack on the first REQ cycle with rdata 0x80AABBCC -> addr 0x1000, strb 0, result 0xFFFFFF80, dst 5, result_valid at T+3.
REQ-025 Store half: op_1 = 0x2002, imm = 0, op_2 = 0x1234ABCD, ack after 3 wait cycles -> wdata 0xABCDABCD, wstrb 0011<<2 = 1100, req held 4 cycles, no result_valid.
REQ-026 Misaligned word at 0x1001 -> no dmem_req_o, misalign_o pulses once, ready_o stays 1.
REQ-027 Kill in REQ: load issued, kill_i high in the first REQ cycle, ack 2 cycles later -> request completes, result_valid_o never asserts, ready_o returns 1.
REQ-028 Reset while dmem_req_o = 1 -> next cycle req = 0, ready_o = 1; a stale ack then produces no result.
REQ-029 Back-to-back: a second issue held high during REQ is not accepted until ready_o returns -> exactly two requests, results in order.
